// File: rtl/lifo_pkg.sv
// Shared types and helpers for the LIFO read-side streaming logic.
//
// Contents:
//   LIFO_DWIDTH / LIFO_AWIDTH_EXP : widths of the LIFO this logic is built against
//   lifo_rd_state_t               : drain FSM states
//   lifo_entry_t                  : skid buffer entry {data, last}
//   lifo_occupancy()              : true word count from the LIFO's full/usedw flags
package lifo_pkg;

  localparam int unsigned LIFO_DWIDTH     = 8;
  localparam int unsigned LIFO_AWIDTH_EXP = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } lifo_rd_state_t;

  typedef struct packed {
    logic [LIFO_DWIDTH-1:0] data;
    logic                   last;
  } lifo_entry_t;

  // usedw wraps to zero when the LIFO is full, so full supplies the missing MSB.
  function automatic logic [LIFO_AWIDTH_EXP:0] lifo_occupancy(
    input logic                       full,
    input logic [LIFO_AWIDTH_EXP-1:0] usedw
  );
    return full ? {1'b1, {LIFO_AWIDTH_EXP{1'b0}}} : {1'b0, usedw};
  endfunction

endpackage

// File: rtl/stream_skid2.sv
// Two-entry FIFO with registered outputs, used as a skid buffer on a valid/ready stream.
//
// The writer has no ready signal: it must track count_o and never present a word when the
// buffer is full and not draining that cycle.
//
// Ports:
//   clk_i       : clock
//   arst_i      : asynchronous reset, active-high
//   in_valid_i  : write in_data_i this cycle
//   in_data_i   : payload to store
//   out_valid_o : head entry is valid
//   out_data_o  : head entry payload (registered)
//   out_ready_i : consumer accepts the head entry
//   count_o     : number of stored entries (0..2)
module stream_skid2 #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       cnt_q;
  logic             pop;

  assign pop = out_ready_i && (cnt_q != 2'd0);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      unique case (cnt_q)
        2'd0: begin
          if (in_valid_i) begin
            head_q <= in_data_i;
            cnt_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && in_valid_i) begin
            head_q <= in_data_i;
          end else if (pop) begin
            cnt_q <= 2'd0;
          end else if (in_valid_i) begin
            tail_q <= in_data_i;
            cnt_q  <= 2'd2;
          end
        end
        2'd2: begin
          if (pop) begin
            head_q <= tail_q;
            if (in_valid_i) begin
              tail_q <= in_data_i;
            end else begin
              cnt_q <= 2'd1;
            end
          end
        end
        default: cnt_q <= 2'd0;
      endcase
    end
  end

  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = head_q;
  assign count_o     = cnt_q;

endmodule

// File: rtl/lifo_rd_stream.sv
// Drains a LIFO as one framed valid/ready stream, newest word first.
//
// A start pulse snapshots the LIFO occupancy; exactly that many words are popped and streamed,
// the final one tagged with last_o. A 2-entry skid buffer absorbs the LIFO's 1-cycle read
// latency so popping can run at one word per cycle without losing data under backpressure.
// DWIDTH and AWIDTH_EXP must equal lifo_pkg::LIFO_DWIDTH / LIFO_AWIDTH_EXP.
//
// Optional feature: define LIFO_RD_STREAM_STATS_EN to add frames_done_o and wr_collisions_o,
// saturating 16-bit counters of completed frames and write-suppressed pop cycles.
//
// Ports:
//   clk_i, arst_i               : clock, asynchronous active-high reset
//   lifo_q_i                    : LIFO read data, valid the cycle after lifo_rdreq_o
//   lifo_empty_i, lifo_full_i   : LIFO flags
//   lifo_usedw_i                : LIFO used words (wraps to 0 when full)
//   lifo_wrreq_i                : upstream write to the same LIFO; blocks a pop that cycle
//   lifo_rdreq_o                : pop request to the LIFO
//   start_i                     : pulse to drain the current contents as one frame
//   busy_o                      : frame in progress
//   frame_len_o                 : length of the most recently accepted frame
//   data_o, valid_o, ready_i, last_o : output stream
module lifo_rd_stream
  import lifo_pkg::*;
#(
  parameter int unsigned DWIDTH     = LIFO_DWIDTH,
  parameter int unsigned AWIDTH_EXP = LIFO_AWIDTH_EXP
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic [DWIDTH-1:0]     lifo_q_i,
  input  logic                  lifo_empty_i,
  input  logic                  lifo_full_i,
  input  logic [AWIDTH_EXP-1:0] lifo_usedw_i,
  input  logic                  lifo_wrreq_i,
  output logic                  lifo_rdreq_o,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic [AWIDTH_EXP:0]   frame_len_o,
  output logic [DWIDTH-1:0]     data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o
`ifdef LIFO_RD_STREAM_STATS_EN
  ,
  output logic [15:0]           frames_done_o,
  output logic [15:0]           wr_collisions_o
`endif
);

  localparam int unsigned CW = AWIDTH_EXP + 1;

  lifo_rd_state_t state_q;
  logic [CW-1:0]  req_left_q;
  logic [CW-1:0]  frame_len_q;
  logic           inflight_q;
  logic           is_last_q;

  logic [CW-1:0]  cnt;
  logic [1:0]     buf_cnt;
  logic           buf_valid;
  logic           xfer;
  logic           pop_ok;
  logic           pop;
  logic [2:0]     credit_used;
  lifo_entry_t    cap_entry;
  lifo_entry_t    head;

  assign cnt  = lifo_occupancy(lifo_full_i, lifo_usedw_i);
  assign xfer = buf_valid && ready_i;

  // Slots committed after this edge: stored words plus the word in flight, minus the word
  // leaving downstream now. Crediting the departing word keeps one pop per cycle sustainable.
  assign credit_used = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, xfer};

  assign pop_ok = (state_q == DRAIN) && (req_left_q != '0) && !lifo_empty_i &&
                  (credit_used < 3'd2);
  // The LIFO ignores a simultaneous read and write, so the pop waits for a free cycle.
  assign pop    = pop_ok && !lifo_wrreq_i;

  assign lifo_rdreq_o = pop;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= IDLE;
      req_left_q  <= '0;
      frame_len_q <= '0;
      inflight_q  <= 1'b0;
      is_last_q   <= 1'b0;
    end else begin
      inflight_q <= pop;
      if (pop) begin
        is_last_q <= (req_left_q == CW'(1));
      end
      unique case (state_q)
        IDLE: begin
          if (start_i && (cnt != '0)) begin
            frame_len_q <= cnt;
            req_left_q  <= cnt;
            state_q     <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop) begin
            req_left_q <= req_left_q - CW'(1);
            if (req_left_q == CW'(1)) begin
              state_q <= FLUSH;
            end
          end
        end
        FLUSH: begin
          // Leave as the tagged word is accepted so busy_o drops right after it.
          if ((xfer && head.last) || (!inflight_q && (buf_cnt == 2'd0))) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cap_entry = '{data: lifo_q_i, last: is_last_q};

  stream_skid2 #(
    .WIDTH($bits(lifo_entry_t))
  ) u_skid (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .in_valid_i (inflight_q),
    .in_data_i  (cap_entry),
    .out_valid_o(buf_valid),
    .out_data_o (head),
    .out_ready_i(ready_i),
    .count_o    (buf_cnt)
  );

  assign busy_o      = (state_q != IDLE);
  assign frame_len_o = frame_len_q;
  assign data_o      = head.data;
  assign valid_o     = buf_valid;
  // The head register keeps its old tag after draining, so qualify it.
  assign last_o      = buf_valid && head.last;

`ifdef LIFO_RD_STREAM_STATS_EN
  logic [15:0] frames_done_q;
  logic [15:0] wr_coll_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      frames_done_q <= '0;
      wr_coll_q     <= '0;
    end else begin
      if (xfer && head.last && (frames_done_q != 16'hFFFF)) begin
        frames_done_q <= frames_done_q + 16'd1;
      end
      if (pop_ok && lifo_wrreq_i && (wr_coll_q != 16'hFFFF)) begin
        wr_coll_q <= wr_coll_q + 16'd1;
      end
    end
  end

  assign frames_done_o   = frames_done_q;
  assign wr_collisions_o = wr_coll_q;
`endif

endmodule

// File: tb/tb_lifo_rd_stream.sv
// Bench for lifo_rd_stream: a behavioural LIFO drives the DUT, expected frames are queued at
// start time from the LIFO contents, and a monitor pops and compares every accepted word.
module tb_lifo_rd_stream;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          arst;
  logic [DW-1:0] lifo_q = '0;
  logic          lifo_empty;
  logic          lifo_full;
  logic [AW-1:0] lifo_usedw;
  logic          lifo_wrreq;
  logic          lifo_rdreq;
  logic          start;
  logic          busy;
  logic [AW:0]   frame_len;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          last;
`ifdef LIFO_RD_STREAM_STATS_EN
  logic [15:0]   frames_done;
  logic [15:0]   wr_coll;
`endif

  always #5 clk = ~clk;

  lifo_rd_stream #(
    .DWIDTH    (DW),
    .AWIDTH_EXP(AW)
  ) dut (
    .clk_i          (clk),
    .arst_i         (arst),
    .lifo_q_i       (lifo_q),
    .lifo_empty_i   (lifo_empty),
    .lifo_full_i    (lifo_full),
    .lifo_usedw_i   (lifo_usedw),
    .lifo_wrreq_i   (lifo_wrreq),
    .lifo_rdreq_o   (lifo_rdreq),
    .start_i        (start),
    .busy_o         (busy),
    .frame_len_o    (frame_len),
    .data_o         (data),
    .valid_o        (valid),
    .ready_i        (ready),
    .last_o         (last)
`ifdef LIFO_RD_STREAM_STATS_EN
    ,
    .frames_done_o  (frames_done),
    .wr_collisions_o(wr_coll)
`endif
  );

  // Behavioural LIFO: registered read data, simultaneous read+write is a no-op.
  logic [DW-1:0] mem [DEPTH];
  int unsigned   sp = 0;
  logic [DW-1:0] wr_data;

  always @(posedge clk) begin
    if (lifo_rdreq && !lifo_wrreq && sp != 0) begin
      lifo_q <= mem[sp-1];
      sp     <= sp - 1;
    end else if (lifo_wrreq && !lifo_rdreq && sp < DEPTH) begin
      mem[sp] <= wr_data;
      sp      <= sp + 1;
    end
  end

  assign lifo_empty = (sp == 0);
  assign lifo_full  = (sp == DEPTH);
  assign lifo_usedw = AW'(sp);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;
  exp_t exp_q[$];

  // Reference: a frame is the whole stack read top-down, tagged on the bottom word.
  task automatic push_stack_frame();
    for (int i = int'(sp) - 1; i >= 0; i--) exp_q.push_back('{d: mem[i], l: (i == 0)});
  endtask

  // Ready driver.
  int ready_mode = 0;
  int rcyc       = 0;
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rcyc++;
      case (ready_mode)
        0:       ready = 1'b1;
        1:       ready = (rcyc % 3 == 0);
        default: ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / scoreboard.
  int n_xfer  = 0;
  int out_cnt = 0;
  int out_max = 0;
  int viol    = 0;
  initial begin
    logic          pv;
    logic          pr;
    logic [DW-1:0] pd;
    logic          pl;
    exp_t          e;
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (arst) begin
        pv      = 1'b0;
        out_cnt = 0;
      end else begin
        if (pv && !pr) begin
          check("hold_valid", 32'(valid), 32'd1);
          check("hold_data", 32'(data), 32'(pd));
          check("hold_last", 32'(last), 32'(pl));
        end
        if (valid && ready) begin
          n_xfer++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_word: got %0h expected none", data);
          end else begin
            e = exp_q.pop_front();
            check("data", 32'(data), 32'(e.d));
            check("last", 32'(last), 32'(e.l));
          end
        end
        if (lifo_rdreq && lifo_wrreq) viol++;
        out_cnt = out_cnt + int'(lifo_rdreq) - int'(valid && ready);
        if (out_cnt > out_max) out_max = out_cnt;
        pv = valid;
        pr = ready;
        pd = data;
        pl = last;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] w);
    lifo_wrreq = 1'b1;
    wr_data    = w;
    tick();
    lifo_wrreq = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdreq"}, 32'(lifo_rdreq), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_last"}, 32'(last), 32'd0);
    check({tag, "_data"}, 32'(data), 32'd0);
    check({tag, "_frame_len"}, 32'(frame_len), 32'd0);
  endtask

  task automatic do_reset();
    arst = 1'b1;
    #1;
    exp_q.delete();
    tick();
    tick();
    arst = 1'b0;
  endtask

  // Pulse start at cycle 0 and observe until busy drops; indices are cycles after the pulse.
  task automatic run_frame(input int budget, output int lat_rd, output int lat_v,
                           output int busy_at, output int idle_at);
    lat_rd  = -1;
    lat_v   = -1;
    busy_at = -1;
    idle_at = -1;
    if (sp != 0) push_stack_frame();
    start = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (lifo_rdreq && lat_rd < 0) lat_rd = i;
      if (valid && lat_v < 0) lat_v = i;
      if (busy && busy_at < 0) busy_at = i;
      if (i > 0 && !busy && idle_at < 0) idle_at = i;
      tick();
      start = 1'b0;
      if (idle_at >= 0) break;
    end
    if (idle_at < 0) begin
      n_checks++;
      $display("FAIL frame_timeout: got busy after %0d cycles expected idle", budget);
    end
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
      tick();
    end
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat_rd, lat_v, busy_at, idle_at, n0, len;
    logic [DW-1:0] wa, wb, wc, wx;

    arst       = 1'b1;
    start      = 1'b0;
    lifo_wrreq = 1'b0;
    wr_data    = '0;
    #1;
    check_reset_outputs("reset");
    tick();
    tick();
    arst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");
    tick();

    // 5-word stack, ready high: latency, throughput, ordering, busy fall.
    for (int i = 1; i <= 5; i++) load(DW'(i * 10));
    n0 = n_xfer;
    run_frame(100, lat_rd, lat_v, busy_at, idle_at);
    check("t1_rdreq_latency", 32'(lat_rd), 32'd1);
    check("t1_busy_latency", 32'(busy_at), 32'd1);
    check("t1_valid_latency", 32'(lat_v), 32'd3);
    check("t1_busy_fall", 32'(idle_at), 32'd8);
    check("t1_frame_len", 32'(frame_len), 32'd5);
    check("t1_words", 32'(n_xfer - n0), 32'd5);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Full stack: usedw wraps to 0.
    for (int i = 0; i < 8; i++) load(DW'($urandom));
    check("t2_full_flag", 32'(lifo_full), 32'd1);
    n0 = n_xfer;
    run_frame(100, lat_rd, lat_v, busy_at, idle_at);
    check("t2_frame_len", 32'(frame_len), 32'd8);
    check("t2_words", 32'(n_xfer - n0), 32'd8);
    check("t2_lifo_empty", 32'(lifo_empty), 32'd1);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Empty LIFO: start is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    n0    = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (lifo_rdreq || busy || valid) n0++;
      tick();
    end
    check("t3_no_activity", 32'(n0), 32'd0);
    check("t3_frame_len_held", 32'(frame_len), 32'd8);

    // Same 5 words with ready toggling 1,0,0.
    for (int i = 1; i <= 5; i++) load(DW'(i * 10));
    ready_mode = 1;
    out_max    = 0;
    n0         = n_xfer;
    run_frame(200, lat_rd, lat_v, busy_at, idle_at);
    ready_mode = 0;
    check("t4_words", 32'(n_xfer - n0), 32'd5);
    check("t4_max_outstanding", 32'(out_max <= 2), 32'd1);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Randomized frames with random backpressure.
    ready_mode = 2;
    for (int f = 0; f < 4; f++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) load(DW'($urandom));
      n0 = n_xfer;
      run_frame(300, lat_rd, lat_v, busy_at, idle_at);
      check("rnd_frame_len", 32'(frame_len), 32'(len));
      check("rnd_words", 32'(n_xfer - n0), 32'(len));
      check("rnd_sb_empty", 32'(exp_q.size()), 32'd0);
    end
    ready_mode = 0;
    tick();

    // Reset after 2 of 4 words; every pop has issued by then, so top up before the next frame.
    for (int i = 0; i < 4; i++) load(DW'($urandom));
    push_stack_frame();
    n0    = n_xfer;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && (n_xfer - n0) < 2; i++) tick();
    check("t5_two_words", 32'(n_xfer - n0), 32'd2);
    arst = 1'b1;
    #1;
    exp_q.delete();
    check_reset_outputs("t5_mid_reset");
    tick();
    tick();
    arst = 1'b0;
    load(DW'($urandom));
    load(DW'($urandom));
    len = int'(sp);
    n0  = n_xfer;
    run_frame(100, lat_rd, lat_v, busy_at, idle_at);
    check("t5_frame_len", 32'(frame_len), 32'(len));
    check("t5_words", 32'(n_xfer - n0), 32'(len));
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Write collision on the 2nd pop slot of a 3-word drain. The blocked cycle lets the write
    // land, so the LIFO hands back the new word next: expected c, x, b(last), a stays behind.
    do_reset();
    wa = DW'($urandom);
    wb = DW'($urandom);
    wc = DW'($urandom);
    wx = DW'($urandom);
    load(wa);
    load(wb);
    load(wc);
    exp_q.push_back('{d: wc, l: 1'b0});
    exp_q.push_back('{d: wx, l: 1'b0});
    exp_q.push_back('{d: wb, l: 1'b1});
    n0    = n_xfer;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    lifo_wrreq = 1'b1;
    wr_data    = wx;
    @(negedge clk);
    check("t6_rdreq_blocked", 32'(lifo_rdreq), 32'd0);
    tick();
    lifo_wrreq = 1'b0;
    wait_idle(100);
    check("t6_frame_len", 32'(frame_len), 32'd3);
    check("t6_words", 32'(n_xfer - n0), 32'd3);
    check("t6_left_in_lifo", 32'(sp), 32'd1);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef LIFO_RD_STREAM_STATS_EN
    check("t6_wr_collisions", 32'(wr_coll), 32'd1);
    check("t6_frames_done", 32'(frames_done), 32'd1);
`endif

    check("rd_wr_overlap", 32'(viol), 32'd0);
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
